z80_bus_responder: RTL
======================

Name: z80_bus_responder

Overview:
- Bus-slave (responder) end of the Z80 external pin interface: watches CPU strobes (nMREQ/nIORQ/nRD/nWR/nM1/nRFSH) and serves memory, I/O and interrupt-acknowledge cycles.
- Sits between the z80_if pins and a simple request/acknowledge backend (RAM model, peripheral fabric).
- Stretches cycles via nWAIT until the backend answers.
- Owns nINT generation and supplies the IM2/IM0 vector byte on interrupt acknowledge.

Parameters:
- WAIT_STATES, 0, extra cycles nWAIT stays low after be_ack (0..15).
- IO_ADDR_BITS, 8, low address bits forwarded for I/O cycles; upper bits zeroed (8 or 16).
- RESET_VECTOR, 8'hFF, int_vector register value after reset.

Ports:
- CLK  in  1  CPU clock; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- A  in  16  CPU address bus.
- D_in  in  8  CPU data bus, sampled for writes.
- D_out  out  8  data driven to CPU.
- D_oe  out  1  D_out drive enable (pin-level tristate is done outside).
- nMREQ, nIORQ, nRD, nWR, nM1, nRFSH  in  1 each  CPU control strobes.
- nWAIT  out  1  wait request to CPU.
- nINT  out  1  maskable interrupt request to CPU.
- int_req  in  1  one-cycle pulse that raises an interrupt.
- int_vector_wr  in  1  load int_vector from int_vector_din.
- int_vector_din  in  8  new vector byte.
- be_req  out  1  backend request, held until be_ack.
- be_we  out  1  1 = write.
- be_io  out  1  1 = I/O space.
- be_addr  out  16  latched address.
- be_wdata  out  8  latched write data.
- be_rdata  in  8  read data, valid with be_ack.
- be_ack  in  1  single-cycle completion.

Behaviour:
- Reset values: nWAIT=1, nINT=1, D_oe=0, D_out=0, be_req=0, be_we=0, be_io=0, be_addr=0, be_wdata=0, int pending=0, int_vector=RESET_VECTOR, state=IDLE.
- Cycle decode (priority order):
  - INTA: !nIORQ & !nM1.
  - REFRESH: !nMREQ & !nRFSH. Ignored, no response.
  - MEMRD: !nMREQ & !nRD.
  - MEMWR: !nMREQ & !nWR.
  - IORD: !nIORQ & !nRD.
  - IOWR: !nIORQ & !nWR.
- States: IDLE, REQ, STRETCH, HOLD.
- IDLE:
  - On MEM/IO decode, latch be_addr (I/O: A[IO_ADDR_BITS-1:0], zero-extended), be_we and be_io. For writes also latch be_wdata=D_in.
  - Assert be_req next cycle. Go to REQ.
  - On INTA, go to HOLD directly with D_out=int_vector, D_oe=1, and clear pending in the same edge.
- nWAIT is combinational. It is 0 when (state==IDLE & MEM/IO decode) or state==REQ or state==STRETCH; otherwise 1. This gives zero-cycle back-pressure.
- REQ:
  - be_req held at 1 until be_ack.
  - On be_ack: be_req=0; for reads capture D_out=be_rdata.
  - Then go to STRETCH if WAIT_STATES>0, else HOLD.
- STRETCH: counter loads WAIT_STATES-1 and decrements to 0, then go to HOLD.
- HOLD:
  - D_oe=1 for reads and INTA.
  - Stays until all of nRD, nWR, nIORQ and (nMREQ or refresh) are deasserted.
  - Then D_oe=0 and return to IDLE the next cycle. No re-trigger while strobes remain low.
- Strobes deasserted while in REQ (aborted cycle): backend transaction still completes. On ack go straight to IDLE, D_oe stays 0.
- be_ack outside REQ: ignored.
- Interrupts:
  - int_req sets pending; nINT = ~pending (registered).
  - int_req coinciding with INTA clear: set wins (re-raise).
  - int_vector_wr takes effect next cycle and does not disturb an in-progress INTA.
- Reset mid-operation: all state and outputs return immediately (asynchronously) to reset values. An outstanding backend request is dropped; the backend must tolerate be_req falling without ack.

Optional Feature:
- Macro Z80_RESP_RETI_DETECT_EN.
- When defined:
  - An in_service flag is set at INTA.
  - While in_service=1, nINT is held 1 even if pending.
  - in_service is cleared when two consecutive M1 opcode fetches (MEMRD with !nM1) return ED then 4D (RETI).
  - An intervening non-M1 cycle does not break the sequence; any other opcode does.
- When undefined: no in_service tracking; nINT follows pending only.

Decomposition:
- Package z80_resp_pkg:
  - typedef enum cycle_t {CYC_NONE, CYC_MEMRD, CYC_MEMWR, CYC_IORD, CYC_IOWR, CYC_INTA, CYC_RFSH}.
  - typedef enum resp_state_t {IDLE, REQ, STRETCH, HOLD}.
  - Constants OPC_ED=8'hED, OPC_RETI2=8'h4D.
- One combinational sub-module z80_cycle_decode: strobes → cycle_t.

Test Plan:
- MEMRD at A=16'h1234: be_ack 3 cycles after be_req with be_rdata=8'h5A → nWAIT low for detect cycle plus REQ cycles; D_out=8'h5A, D_oe=1 until nRD rises; be_we=0, be_io=0.
- MEMWR D_in=8'hC3 at 16'h8000 with WAIT_STATES=2 → be_wdata=8'hC3, be_we=1; nWAIT released exactly 2 cycles after be_ack; D_oe stays 0.
- IOWR at A=16'hAB10 with IO_ADDR_BITS=8 → be_addr=16'h0010, be_io=1.
- int_req pulse → nINT=0 next cycle. INTA with int_vector=8'h20 → D_out=8'h20, D_oe=1, nWAIT stays 1, nINT=1 after the cycle. Refresh cycle (!nMREQ & !nRFSH) produces no be_req.
- nRESET low mid-REQ → be_req, nWAIT, D_oe return to reset values without waiting for CLK; the next MEMRD after release is served normally.
- With Z80_RESP_RETI_DETECT_EN: INTA, then int_req → nINT stays 1; M1 fetches ED, 4D → nINT=0 next cycle. A fetch sequence ED, 45 leaves nINT=1.

Source files
------------

// File: rtl/z80_bus_responder_pkg.sv
// Shared types and constants for the Z80 bus responder: cycle kinds, FSM states,
// RETI opcode bytes and the I/O address mask helper.
package z80_resp_pkg;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_MEMRD,
    CYC_MEMWR,
    CYC_IORD,
    CYC_IOWR,
    CYC_INTA,
    CYC_RFSH
  } cycle_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STRETCH,
    HOLD
  } resp_state_t;

  localparam logic [7:0] OPC_ED    = 8'hED;
  localparam logic [7:0] OPC_RETI2 = 8'h4D;

  // Mask keeping the low 'bits' address lines of an I/O cycle.
  function automatic logic [15:0] io_addr_mask(input int bits);
    return (bits >= 16) ? 16'hFFFF : 16'((32'h1 << bits) - 32'h1);
  endfunction

endpackage

// File: rtl/z80_bus_responder_cycle_decode.sv
// Combinational classification of the Z80 control strobes into one bus cycle kind,
// resolved in priority order (INTA, refresh, memory, I/O).
module z80_cycle_decode
  import z80_resp_pkg::*;
(
  input  logic   nMREQ,
  input  logic   nIORQ,
  input  logic   nRD,
  input  logic   nWR,
  input  logic   nM1,
  input  logic   nRFSH,
  output cycle_t cyc
);

  always_comb begin
    cyc = CYC_NONE;
    if (!nIORQ && !nM1)      cyc = CYC_INTA;
    else if (!nMREQ && !nRFSH) cyc = CYC_RFSH;
    else if (!nMREQ && !nRD)   cyc = CYC_MEMRD;
    else if (!nMREQ && !nWR)   cyc = CYC_MEMWR;
    else if (!nIORQ && !nRD)   cyc = CYC_IORD;
    else if (!nIORQ && !nWR)   cyc = CYC_IOWR;
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus-slave front end: serves memory/I/O/INTA cycles through a req/ack backend,
// stretching with nWAIT, and drives nINT. Optional macro: Z80_RESP_RETI_DETECT_EN.
//
//   state   | meaning
//   IDLE    | waiting for a CPU cycle; nWAIT pulled low as soon as MEM/IO decodes
//   REQ     | be_req held until be_ack
//   STRETCH | WAIT_STATES extra nWAIT cycles after the ack
//   HOLD    | data presented (reads/INTA) until the CPU drops its strobes
module z80_bus_responder
  import z80_resp_pkg::*;
#(
  parameter int         WAIT_STATES  = 0,
  parameter int         IO_ADDR_BITS = 8,
  parameter logic [7:0] RESET_VECTOR = 8'hFF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic        nRFSH,
  output logic        nWAIT,
  output logic        nINT,
  input  logic        int_req,
  input  logic        int_vector_wr,
  input  logic [7:0]  int_vector_din,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack
);

  localparam logic [15:0] IO_MASK = io_addr_mask(IO_ADDR_BITS);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  cycle_t      cyc;
  resp_state_t state, state_nx;
  logic        bus_cyc, is_write, is_io, released, inta_take, aborted;
  logic        n_wait_c, pending;
  logic [3:0]  ws_cnt;
  logic [7:0]  int_vector;

  z80_cycle_decode u_decode (
    .nMREQ (nMREQ),
    .nIORQ (nIORQ),
    .nRD   (nRD),
    .nWR   (nWR),
    .nM1   (nM1),
    .nRFSH (nRFSH),
    .cyc   (cyc)
  );

  assign bus_cyc   = (cyc == CYC_MEMRD) || (cyc == CYC_MEMWR) || (cyc == CYC_IORD) || (cyc == CYC_IOWR);
  assign is_write  = (cyc == CYC_MEMWR) || (cyc == CYC_IOWR);
  assign is_io     = (cyc == CYC_IORD) || (cyc == CYC_IOWR);
  // A refresh MREQ right after M1 must not keep the cycle alive.
  assign released  = nRD & nWR & nIORQ & (nMREQ | ~nRFSH);
  assign inta_take = (state == IDLE) && (cyc == CYC_INTA);
  assign nWAIT     = n_wait_c;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    n_wait_c = 1'b1;
    case (state)
      IDLE: begin
        if (bus_cyc) begin
          state_nx = REQ;
          n_wait_c = 1'b0;
        end else if (cyc == CYC_INTA) begin
          state_nx = HOLD;
        end
      end
      REQ: begin
        n_wait_c = 1'b0;
        if (be_ack) begin
          if (aborted || released) state_nx = IDLE;
          else if (WAIT_STATES > 0) state_nx = STRETCH;
          else                      state_nx = HOLD;
        end
      end
      STRETCH: begin
        n_wait_c = 1'b0;
        if (ws_cnt == 4'd0) state_nx = HOLD;
      end
      HOLD: begin
        if (released) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      be_req   <= 1'b0;
      be_we    <= 1'b0;
      be_io    <= 1'b0;
      be_addr  <= '0;
      be_wdata <= '0;
      D_out    <= '0;
      D_oe     <= 1'b0;
      aborted  <= 1'b0;
      ws_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_cyc) begin
            be_req  <= 1'b1;
            be_we   <= is_write;
            be_io   <= is_io;
            be_addr <= is_io ? (A & IO_MASK) : A;
            aborted <= 1'b0;
            if (is_write) be_wdata <= D_in;
          end else if (cyc == CYC_INTA) begin
            D_out <= int_vector;
            D_oe  <= 1'b1;
          end
        end
        REQ: begin
          if (released) aborted <= 1'b1;
          if (be_ack) begin
            be_req <= 1'b0;
            ws_cnt <= WS_LOAD;
            if (!be_we) D_out <= be_rdata;
            if (state_nx == HOLD && !be_we) D_oe <= 1'b1;
          end
        end
        STRETCH: begin
          if (ws_cnt != 4'd0) ws_cnt <= ws_cnt - 4'd1;
          if (state_nx == HOLD && !be_we) D_oe <= 1'b1;
        end
        HOLD: begin
          if (released) D_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A new request beats an acknowledge clear on the same edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      int_vector <= RESET_VECTOR;
      pending    <= 1'b0;
    end else begin
      if (int_vector_wr) int_vector <= int_vector_din;
      if (int_req)        pending <= 1'b1;
      else if (inta_take) pending <= 1'b0;
    end
  end

`ifdef Z80_RESP_RETI_DETECT_EN
  logic in_service, saw_ed, fetch_m1, opcode_take;

  assign opcode_take = (state == REQ) && be_ack && fetch_m1;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      in_service <= 1'b0;
      saw_ed     <= 1'b0;
      fetch_m1   <= 1'b0;
    end else begin
      if ((state == IDLE) && bus_cyc) fetch_m1 <= (cyc == CYC_MEMRD) && !nM1;
      if (inta_take) begin
        in_service <= 1'b1;
        saw_ed     <= 1'b0;
      end else if (opcode_take) begin
        saw_ed <= (be_rdata == OPC_ED);
        if (saw_ed && (be_rdata == OPC_RETI2)) in_service <= 1'b0;
      end
    end
  end

  assign nINT = ~(pending & ~in_service);
`else
  assign nINT = ~pending;
`endif

endmodule
